sw_debounce_sync: RTL and testbench

//  Per-channel switch conditioner between board slide switches and the counter/toggle

---
 rtl/sw_debounce_sync_if.sv | 24 ++
 rtl/sw_debounce_sync.sv | 127 ++++++++++++
 tb/tb_sw_debounce_sync.sv | 164 ++++++++++++++++
 3 files changed

// File: rtl/sw_debounce_sync_if.sv
// Switch-side bundle: raw switch levels in, debounced level and edge pulses out.
// Latency: none (wires only). Backpressure: none, levels and pulses are free-running.
interface sw_debounce_sync_if #(
    parameter int N_CH = 4
);
    logic [N_CH-1:0] i_sw;
    logic [N_CH-1:0] o_sw_db;
    logic [N_CH-1:0] o_rise;
    logic [N_CH-1:0] o_fall;

    modport master (
        output i_sw,
        input  o_sw_db,
        input  o_rise,
        input  o_fall
    );

    modport slave (
        input  i_sw,
        output o_sw_db,
        output o_rise,
        output o_fall
    );
endinterface

// File: rtl/sw_debounce_sync.sv
// Per-channel switch conditioner: synchroniser, stable-sample debounce, clean level and edge pulses.
// Latency: SYNC_STAGES+DEBOUNCE_CNT-1 edges from the sampling edge to the level change.
// Backpressure: none; pulses are single-cycle and never held for the consumer.
module sw_debounce_sync #(
    parameter int N_CH         = 4,
    parameter int SYNC_STAGES  = 2,
    parameter int DEBOUNCE_CNT = 1000000,
    parameter int CNT_W        = 20
) (
    input  logic               clk,
    input  logic               reset_n,
    sw_debounce_sync_if.slave  bus
);

    typedef enum logic [1:0] {
        S_LO  = 2'd0,
        S_WHI = 2'd1,
        S_HI  = 2'd2,
        S_WLO = 2'd3
    } state_t;

    // Count value on the edge that registers the final required sample.
    localparam int             CNT_TGT = (DEBOUNCE_CNT >= 2) ? (DEBOUNCE_CNT - 2) : 0;
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(CNT_TGT);
    localparam bit             ONE_SHOT = (DEBOUNCE_CNT == 1);

    logic [N_CH-1:0]  sync_q [SYNC_STAGES];
    logic [N_CH-1:0]  s;
    state_t           st     [N_CH];
    logic [CNT_W-1:0] cnt    [N_CH];
    logic [N_CH-1:0]  db_q;
    logic [N_CH-1:0]  rise_q;
    logic [N_CH-1:0]  fall_q;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int k = 0; k < SYNC_STAGES; k++) begin
                sync_q[k] <= '0;
            end
        end else begin
            sync_q[0] <= bus.i_sw;
            for (int k = 1; k < SYNC_STAGES; k++) begin
                sync_q[k] <= sync_q[k-1];
            end
        end
    end

    assign s = sync_q[SYNC_STAGES-1];

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < N_CH; i++) begin
                st[i]  <= S_LO;
                cnt[i] <= '0;
            end
            db_q   <= '0;
            rise_q <= '0;
            fall_q <= '0;
        end else begin
            for (int i = 0; i < N_CH; i++) begin
                rise_q[i] <= 1'b0;
                fall_q[i] <= 1'b0;
                case (st[i])
                    S_LO: begin
                        if (s[i]) begin
                            cnt[i] <= '0;
                            if (ONE_SHOT) begin
                                st[i]     <= S_HI;
                                db_q[i]   <= 1'b1;
                                rise_q[i] <= 1'b1;
                            end else begin
                                st[i] <= S_WHI;
                            end
                        end
                    end
                    S_WHI: begin
                        if (!s[i]) begin
                            st[i]  <= S_LO;
                            cnt[i] <= '0;
                        end else if (cnt[i] == CNT_MAX) begin
                            st[i]     <= S_HI;
                            cnt[i]    <= '0;
                            db_q[i]   <= 1'b1;
                            rise_q[i] <= 1'b1;
                        end else begin
                            cnt[i] <= cnt[i] + 1'b1;
                        end
                    end
                    S_HI: begin
                        if (!s[i]) begin
                            cnt[i] <= '0;
                            if (ONE_SHOT) begin
                                st[i]     <= S_LO;
                                db_q[i]   <= 1'b0;
                                fall_q[i] <= 1'b1;
                            end else begin
                                st[i] <= S_WLO;
                            end
                        end
                    end
                    S_WLO: begin
                        if (s[i]) begin
                            st[i]  <= S_HI;
                            cnt[i] <= '0;
                        end else if (cnt[i] == CNT_MAX) begin
                            st[i]     <= S_LO;
                            cnt[i]    <= '0;
                            db_q[i]   <= 1'b0;
                            fall_q[i] <= 1'b1;
                        end else begin
                            cnt[i] <= cnt[i] + 1'b1;
                        end
                    end
                    default: begin
                        st[i]  <= S_LO;
                        cnt[i] <= '0;
                    end
                endcase
            end
        end
    end

    assign bus.o_sw_db = db_q;
    assign bus.o_rise  = rise_q;
    assign bus.o_fall  = fall_q;

endmodule

// File: tb/tb_sw_debounce_sync.sv
// Directed bench for sw_debounce_sync with a 4-sample debounce window and 2-flop synchroniser.
module tb_sw_debounce_sync;

    logic clk;
    logic reset_n;
    int   total;
    int   bad;

    sw_debounce_sync_if #(.N_CH(4)) swif ();

    sw_debounce_sync #(
        .N_CH(4), .SYNC_STAGES(2), .DEBOUNCE_CNT(4), .CNT_W(2)
    ) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (swif.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [3:0] got, input logic [3:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // Advance n rising edges; return 1 time unit after the last one.
    task automatic tick(input int n);
        for (int k = 0; k < n; k++) begin
            @(posedge clk);
            #1;
        end
    endtask

    logic [3:0] acc;

    initial begin
        total = 0;
        bad   = 0;
        acc   = '0;

        // 1: reset with all switches high, then treated as fresh rise
        reset_n   = 1'b0;
        swif.i_sw = 4'hF;
        tick(3);
        chk("rst_db",   swif.o_sw_db, 4'h0);
        chk("rst_rise", swif.o_rise,  4'h0);
        chk("rst_fall", swif.o_fall,  4'h0);
        reset_n = 1'b1;
        tick(5);
        chk("rel_db_e4",   swif.o_sw_db, 4'h0);
        chk("rel_rise_e4", swif.o_rise,  4'h0);
        tick(1);
        chk("rel_db_e5",   swif.o_sw_db, 4'hF);
        chk("rel_rise_e5", swif.o_rise,  4'hF);
        tick(1);
        chk("rel_rise_e6", swif.o_rise,  4'h0);
        chk("rel_db_e6",   swif.o_sw_db, 4'hF);

        swif.i_sw = 4'h0;
        tick(5);
        chk("all_lo_db_e4", swif.o_sw_db, 4'hF);
        tick(1);
        chk("all_lo_db_e5",   swif.o_sw_db, 4'h0);
        chk("all_lo_fall_e5", swif.o_fall,  4'hF);
        tick(1);
        chk("all_lo_fall_e6", swif.o_fall,  4'h0);

        // 2: clean step on channel 0
        swif.i_sw = 4'b0001;
        tick(5);
        chk("c0_up_db_e4", swif.o_sw_db, 4'h0);
        tick(1);
        chk("c0_up_db_e5",   swif.o_sw_db, 4'b0001);
        chk("c0_up_rise_e5", swif.o_rise,  4'b0001);
        chk("c0_up_fall_e5", swif.o_fall,  4'b0000);
        tick(1);
        chk("c0_up_rise_e6", swif.o_rise,  4'b0000);
        swif.i_sw = 4'b0000;
        tick(5);
        chk("c0_dn_db_e4",   swif.o_sw_db, 4'b0001);
        chk("c0_dn_fall_e4", swif.o_fall,  4'b0000);
        tick(1);
        chk("c0_dn_db_e5",   swif.o_sw_db, 4'b0000);
        chk("c0_dn_fall_e5", swif.o_fall,  4'b0001);
        chk("c0_dn_rise_e5", swif.o_rise,  4'b0000);
        tick(1);
        chk("c0_dn_fall_e6", swif.o_fall,  4'b0000);

        // 3: bounce on channel 1, then held high
        acc = '0;
        for (int k = 0; k < 4; k++) begin
            swif.i_sw = (k % 2 == 0) ? 4'b0010 : 4'b0000;
            tick(1);
            acc = acc | swif.o_sw_db | swif.o_rise | swif.o_fall;
        end
        swif.i_sw = 4'b0010;
        for (int k = 0; k < 5; k++) begin
            tick(1);
            acc = acc | swif.o_sw_db | swif.o_rise | swif.o_fall;
        end
        chk("bounce_quiet", acc, 4'h0);
        tick(1);
        chk("bounce_db_e5",   swif.o_sw_db, 4'b0010);
        chk("bounce_rise_e5", swif.o_rise,  4'b0010);
        swif.i_sw = 4'b0000;
        tick(8);
        chk("bounce_back_lo", swif.o_sw_db, 4'b0000);

        // 4: channel 2 high for only 3 cycles
        acc = '0;
        swif.i_sw = 4'b0100;
        for (int k = 0; k < 3; k++) begin
            tick(1);
            acc = acc | swif.o_sw_db | swif.o_rise;
        end
        swif.i_sw = 4'b0000;
        for (int k = 0; k < 10; k++) begin
            tick(1);
            acc = acc | swif.o_sw_db | swif.o_rise;
        end
        chk("short_pulse", acc, 4'h0);

        // 5: simultaneous rise on three channels
        swif.i_sw = 4'b1011;
        tick(5);
        chk("simul_rise_e4", swif.o_rise, 4'b0000);
        tick(1);
        chk("simul_rise_e5", swif.o_rise,  4'b1011);
        chk("simul_db_e5",   swif.o_sw_db, 4'b1011);
        tick(1);
        chk("simul_rise_e6", swif.o_rise,  4'b0000);
        swif.i_sw = 4'b0000;
        tick(6);
        chk("simul_fall_e5", swif.o_fall,  4'b1011);
        tick(2);
        chk("simul_back_lo", swif.o_sw_db, 4'b0000);

        // 6: reset while channel 3 is mid-count and channel 0 is settled high
        swif.i_sw = 4'b0001;
        tick(7);
        chk("pre_rst_db", swif.o_sw_db, 4'b0001);
        swif.i_sw = 4'b1001;
        tick(2);
        reset_n = 1'b0;
        #1;
        chk("mid_rst_db",   swif.o_sw_db, 4'b0000);
        chk("mid_rst_rise", swif.o_rise,  4'b0000);
        tick(2);
        reset_n = 1'b1;
        tick(5);
        chk("restart_db_e4", swif.o_sw_db, 4'b0000);
        tick(1);
        chk("restart_db_e5",   swif.o_sw_db, 4'b1001);
        chk("restart_rise_e5", swif.o_rise,  4'b1001);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
